// File: rtl/reloj_alarma_nucleo.sv
// reloj_alarma_nucleo: timekeeping core of the alarm clock.
// Keeps current time (BCD HH:MM plus a binary seconds count) and alarm time
// (BCD HH:MM), handles the set-time / set-alarm buttons, and raises a
// registered alarm flag on a match that auto-clears after ALARMA_DUR ticks.
//
// Ports:
//   i_relojete   system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_tick_seg   one-cycle pulse per second
//   i_modo       00 run, 01 set time, 10 set alarm, 11 same as 00
//   i_btn_min    minute increment pulse for the selected register
//   i_btn_hora   hour increment pulse for the selected register
//   i_alarma_en  alarm enable level
//   i_apagar     alarm-off request
//   o_c0..o_c3   BCD digits: minute units, minute tens, hour units, hour tens
//   o_punto      colon blink, toggles on every counted tick
//   o_alarma     alarm/buzzer flag
module reloj_alarma_nucleo #(
  parameter int SEG_POR_MIN = 60,
  parameter int ALARMA_DUR  = 60
) (
  input  logic       i_relojete,
  input  logic       i_reset,
  input  logic       i_tick_seg,
  input  logic [1:0] i_modo,
  input  logic       i_btn_min,
  input  logic       i_btn_hora,
  input  logic       i_alarma_en,
  input  logic       i_apagar,
  output logic [3:0] o_c0,
  output logic [3:0] o_c1,
  output logic [3:0] o_c2,
  output logic [3:0] o_c3,
  output logic       o_punto,
  output logic       o_alarma
);

  localparam int SW = (SEG_POR_MIN > 1) ? $clog2(SEG_POR_MIN) : 1;
  localparam int DW = $clog2(ALARMA_DUR + 1);

  localparam logic [1:0] MODO_SET_HORA  = 2'b01;
  localparam logic [1:0] MODO_SET_ALARM = 2'b10;

  // {tens, units} BCD increment with wrap 59 -> 00
  function automatic logic [7:0] inc_min(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  // {tens, units} BCD increment with wrap 23 -> 00
  function automatic logic [7:0] inc_hora(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v == 8'h23) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  logic [SW-1:0] r_seg;
  logic [7:0]    r_min, r_hora, r_al_min, r_al_hora;
  logic          r_punto, r_alarma;
  logic [DW-1:0] r_dur;

  logic          w_cuenta, w_seg_wrap, w_min_wrap, w_disparo, w_fin_dur;
  logic [7:0]    w_min_sig, w_hora_sig;
  logic [DW-1:0] w_dur_sig;

  // Ticks are counted in every mode except set-time
  assign w_cuenta   = i_tick_seg && (i_modo != MODO_SET_HORA);
  assign w_seg_wrap = (r_seg == SW'(SEG_POR_MIN - 1));
  assign w_min_wrap = w_cuenta && w_seg_wrap;
  assign w_min_sig  = w_min_wrap ? inc_min(r_min) : r_min;
  assign w_hora_sig = (w_min_wrap && r_min == 8'h59) ? inc_hora(r_hora) : r_hora;

  // Match is checked against the HH:MM this edge produces, so the flag rises
  // together with the minute rollover into the alarm minute.
  assign w_disparo = w_min_wrap && i_alarma_en &&
                     ({w_hora_sig, w_min_sig} == {r_al_hora, r_al_min});
  assign w_dur_sig = r_dur + DW'(1);
  assign w_fin_dur = r_alarma && i_tick_seg && (w_dur_sig == DW'(ALARMA_DUR));

  always_ff @(posedge i_relojete or posedge i_reset) begin
    if (i_reset) begin
      r_seg   <= '0;
      r_min   <= 8'h00;
      r_hora  <= 8'h00;
      r_punto <= 1'b0;
    end else if (i_modo == MODO_SET_HORA) begin
      r_seg <= '0;
      if (i_btn_min)  r_min  <= inc_min(r_min);
      if (i_btn_hora) r_hora <= inc_hora(r_hora);
    end else if (w_cuenta) begin
      r_seg   <= w_seg_wrap ? '0 : r_seg + SW'(1);
      r_min   <= w_min_sig;
      r_hora  <= w_hora_sig;
      r_punto <= ~r_punto;
    end
  end

  always_ff @(posedge i_relojete or posedge i_reset) begin
    if (i_reset) begin
      r_al_min  <= 8'h00;
      r_al_hora <= 8'h00;
    end else if (i_modo == MODO_SET_ALARM) begin
      if (i_btn_min)  r_al_min  <= inc_min(r_al_min);
      if (i_btn_hora) r_al_hora <= inc_hora(r_al_hora);
    end
  end

  // Off request beats duration timeout, which beats a new trigger
  always_ff @(posedge i_relojete or posedge i_reset) begin
    if (i_reset) begin
      r_alarma <= 1'b0;
      r_dur    <= '0;
    end else if (i_apagar || !i_alarma_en) begin
      r_alarma <= 1'b0;
    end else if (w_fin_dur) begin
      r_alarma <= 1'b0;
      r_dur    <= w_dur_sig;
    end else if (w_disparo) begin
      r_alarma <= 1'b1;
      r_dur    <= '0;
    end else if (r_alarma && i_tick_seg) begin
      r_dur <= w_dur_sig;
    end
  end

  logic w_ver_alarma;
  assign w_ver_alarma = (i_modo == MODO_SET_ALARM);

  assign o_c0     = w_ver_alarma ? r_al_min[3:0]  : r_min[3:0];
  assign o_c1     = w_ver_alarma ? r_al_min[7:4]  : r_min[7:4];
  assign o_c2     = w_ver_alarma ? r_al_hora[3:0] : r_hora[3:0];
  assign o_c3     = w_ver_alarma ? r_al_hora[7:4] : r_hora[7:4];
  assign o_punto  = r_punto;
  assign o_alarma = r_alarma;

endmodule

// File: tb/tb_reloj_alarma_nucleo.sv
module tb_reloj_alarma_nucleo;

  localparam int SPM = 4;
  localparam int DUR = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] modo = 2'b00;
  logic       bmin = 1'b0, bhora = 1'b0, en = 1'b0, apagar = 1'b0;
  logic [3:0] c0, c1, c2, c3;
  logic       punto, alarma;

  int n_vec = 0;
  int n_err = 0;

  reloj_alarma_nucleo #(.SEG_POR_MIN(SPM), .ALARMA_DUR(DUR)) dut (
    .i_relojete (clk),
    .i_reset    (rst),
    .i_tick_seg (tick),
    .i_modo     (modo),
    .i_btn_min  (bmin),
    .i_btn_hora (bhora),
    .i_alarma_en(en),
    .i_apagar   (apagar),
    .o_c0       (c0),
    .o_c1       (c1),
    .o_c2       (c2),
    .o_c3       (c3),
    .o_punto    (punto),
    .o_alarma   (alarma)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  modo;
    logic        tick;
    logic        bmin;
    logic        bhora;
    logic [15:0] disp;
    logic        p;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] disp();
    return {c3, c2, c1, c0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick = 0; bmin = 0; bhora = 0; apagar = 0; en = 0; modo = 2'b00;
    rst = 1;
    #2;
    rst = 0;
  endtask

  task automatic press(input logic m, input logic h);
    bmin = m; bhora = h;
    step();
    bmin = 0; bhora = 0;
  endtask

  task automatic ticks(input int n);
    tick = 1;
    for (int i = 0; i < n; i++) step();
    tick = 0;
  endtask

  initial begin
    // modo, tick, bmin, bhora, expected HHMM, expected punto
    tbl[0]  = '{2'b01, 1, 0, 0, 16'h0000, 0};
    tbl[1]  = '{2'b01, 0, 1, 0, 16'h0001, 0};
    tbl[2]  = '{2'b01, 0, 1, 1, 16'h0102, 0};
    tbl[3]  = '{2'b00, 1, 1, 0, 16'h0102, 1};
    tbl[4]  = '{2'b11, 1, 0, 0, 16'h0102, 0};
    tbl[5]  = '{2'b11, 0, 0, 1, 16'h0102, 0};
    tbl[6]  = '{2'b00, 1, 0, 0, 16'h0102, 1};
    tbl[7]  = '{2'b00, 1, 0, 0, 16'h0103, 0};
    tbl[8]  = '{2'b10, 0, 1, 0, 16'h0001, 0};
    tbl[9]  = '{2'b10, 0, 0, 1, 16'h0101, 0};
    tbl[10] = '{2'b10, 1, 0, 0, 16'h0101, 1};
    tbl[11] = '{2'b00, 0, 0, 0, 16'h0103, 1};
    tbl[12] = '{2'b01, 0, 0, 0, 16'h0103, 1};
    tbl[13] = '{2'b00, 1, 0, 0, 16'h0103, 0};
    tbl[14] = '{2'b00, 1, 0, 0, 16'h0103, 1};
    tbl[15] = '{2'b00, 1, 0, 0, 16'h0103, 0};
    tbl[16] = '{2'b00, 1, 0, 0, 16'h0104, 1};

    rst = 1;
    #2;
    chk("reset_disp", disp(), 16'h0000);
    chk("reset_flags", {14'd0, punto, alarma}, 16'h0000);
    #1 rst = 0;
    step();

    for (int i = 0; i < 17; i++) begin
      modo = tbl[i].modo; tick = tbl[i].tick; bmin = tbl[i].bmin; bhora = tbl[i].bhora;
      step();
      chk($sformatf("vec%0d_disp", i), disp(), tbl[i].disp);
      chk($sformatf("vec%0d_punto", i), {15'd0, punto}, {15'd0, tbl[i].p});
      chk($sformatf("vec%0d_alarma", i), {15'd0, alarma}, 16'h0000);
    end
    tick = 0; bmin = 0; bhora = 0;

    // Rollover 23:59 -> 00:00
    do_reset();
    modo = 2'b01;
    for (int i = 0; i < 23; i++) press(1, 1);
    for (int i = 0; i < 36; i++) press(1, 0);
    chk("roll_set", disp(), 16'h2359);
    modo = 2'b00;
    for (int i = 1; i <= SPM; i++) begin
      ticks(1);
      chk($sformatf("roll_punto%0d", i), {15'd0, punto}, {15'd0, logic'(i % 2)});
      if (i < SPM) chk($sformatf("roll_hold%0d", i), disp(), 16'h2359);
    end
    chk("roll_wrap", disp(), 16'h0000);

    // Set-mode wraps, ticks ignored, seconds held at 0
    do_reset();
    modo = 2'b01;
    for (int i = 0; i < 5; i++) press(0, 1);
    tick = 1;
    for (int i = 0; i < 60; i++) press(1, 0);
    chk("setwrap_min", disp(), 16'h0500);
    for (int i = 0; i < 24; i++) press(0, 1);
    chk("setwrap_hora24", disp(), 16'h0500);
    for (int i = 0; i < 19; i++) press(0, 1);
    tick = 0;
    chk("setwrap_hora0", disp(), 16'h0000);
    chk("setwrap_punto", {15'd0, punto}, 16'h0000);
    modo = 2'b00;
    ticks(SPM - 1);
    chk("setwrap_seg0", disp(), 16'h0000);
    ticks(1);
    chk("setwrap_seg_roll", disp(), 16'h0001);

    // Alarm match and duration timeout
    do_reset();
    modo = 2'b10;
    press(1, 0);
    chk("alm_set", disp(), 16'h0001);
    modo = 2'b00; en = 1;
    ticks(SPM - 1);
    chk("alm_before", {15'd0, alarma}, 16'h0000);
    ticks(1);
    chk("alm_match_disp", disp(), 16'h0001);
    chk("alm_match", {15'd0, alarma}, 16'h0001);
    modo = 2'b10;
    press(1, 0);
    press(1, 0);
    chk("alm_edit_keeps", {15'd0, alarma}, 16'h0001);
    chk("alm_edit_disp", disp(), 16'h0003);
    modo = 2'b00;
    ticks(DUR - 1);
    chk("alm_dur_hold", {15'd0, alarma}, 16'h0001);
    chk("alm_dur_time", disp(), 16'h0002);
    ticks(1);
    chk("alm_dur_off", {15'd0, alarma}, 16'h0000);

    // apagar on the matching tick, then apagar while active
    do_reset();
    modo = 2'b10;
    press(1, 0);
    modo = 2'b00; en = 1;
    ticks(SPM - 1);
    apagar = 1;
    ticks(1);
    apagar = 0;
    chk("apg_same_disp", disp(), 16'h0001);
    chk("apg_same", {15'd0, alarma}, 16'h0000);
    modo = 2'b10;
    press(1, 0);
    modo = 2'b00;
    ticks(SPM);
    chk("apg_rearm", {15'd0, alarma}, 16'h0001);
    apagar = 1;
    step();
    apagar = 0;
    chk("apg_active", {15'd0, alarma}, 16'h0000);

    // Disabled alarm at a match
    do_reset();
    modo = 2'b10;
    press(1, 0);
    modo = 2'b00; en = 0;
    ticks(SPM);
    chk("en0_disp", disp(), 16'h0001);
    chk("en0_alarm", {15'd0, alarma}, 16'h0000);

    // Sitting in set-time mode on the alarm time
    do_reset();
    modo = 2'b10;
    press(1, 0);
    modo = 2'b01; en = 1;
    press(1, 0);
    ticks(2 * SPM);
    chk("set_mode_disp", disp(), 16'h0001);
    chk("set_mode_alarm", {15'd0, alarma}, 16'h0000);

    // Asynchronous reset while alarm active at 12:34
    do_reset();
    modo = 2'b01;
    for (int i = 0; i < 12; i++) press(0, 1);
    for (int i = 0; i < 33; i++) press(1, 0);
    modo = 2'b10;
    for (int i = 0; i < 12; i++) press(0, 1);
    for (int i = 0; i < 34; i++) press(1, 0);
    chk("ares_alm_set", disp(), 16'h1234);
    modo = 2'b00; en = 1;
    ticks(SPM + 1);
    chk("ares_pre_disp", disp(), 16'h1234);
    chk("ares_pre_flags", {14'd0, punto, alarma}, 16'h0003);
    #3 rst = 1;
    #1;
    chk("ares_disp", disp(), 16'h0000);
    chk("ares_flags", {14'd0, punto, alarma}, 16'h0000);
    #1 rst = 0;
    ticks(SPM);
    chk("ares_restart", disp(), 16'h0001);
    chk("ares_restart_alarm", {15'd0, alarma}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
